// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank writeback path.
// The write entry type is the unit buffered between the MDU and the write port.
package regbank_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_FIFO
  } wb_src_t;
endpackage

// File: rtl/regbank_wb_ctrl_if.sv
// Bundle of producer, decode-query and register-bank write signals for the
// writeback controller. The controller sits on the slave side.
interface regbank_wb_ctrl_if
  import regbank_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
);
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_addr;
  logic [DW-1:0] mdu_data;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] r0Addr;
  logic [AW-1:0] r1Addr;
  logic          r0_busy;
  logic          r1_busy;
  logic          alu_stall;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic          wEn;
  logic          err;

  modport master (
    output alu_valid, alu_addr, alu_data, mdu_valid, mdu_addr, mdu_data,
           issue_valid, issue_addr, r0Addr, r1Addr,
    input  mdu_ready, r0_busy, r1_busy, alu_stall, wAddr, wData, wEn, err
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mdu_valid, mdu_addr, mdu_data,
           issue_valid, issue_addr, r0Addr, r1Addr,
    output mdu_ready, r0_busy, r1_busy, alu_stall, wAddr, wData, wEn, err
  );
endinterface

// File: rtl/regbank_wb_ctrl_fifo.sv
// Small synchronous FIFO buffering MDU results; head is the oldest entry.
// Depth must be a power of two so the pointers wrap naturally.
module wb_fifo
  import regbank_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/regbank_wb_ctrl.sv
// Register-bank writeback arbiter: ALU results win, MDU results drain from a
// FIFO when the ALU is idle; tracks pending MDU writes for hazard stalls.
module regbank_wb_ctrl
  import regbank_pkg::*;
#(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic              CLK,
  input logic              reset,
  regbank_wb_ctrl_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t           push_entry;
  entry_t           head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             push;
  logic             pop;
  wb_src_t          src;
  logic [2**AW-1:0] busy;
  logic [2**AW-1:0] busy_next;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_next;
  logic             wen_q;
  logic [AW-1:0]    waddr_q;
  logic [DW-1:0]    wdata_q;
  logic             stall_q;
  logic             err_q;

  assign bus.mdu_ready = (fifo_count != CW'(FIFO_DEPTH)) && !reset;
  assign push          = bus.mdu_valid && bus.mdu_ready && !fifo_full &&
                         (bus.mdu_addr != REG_ZERO);
  // Any ALU result, even to r0, owns the write port this cycle.
  assign pop           = !bus.alu_valid && !fifo_empty;
  assign push_entry    = '{addr: bus.mdu_addr, data: bus.mdu_data};

  wb_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    src = WB_NONE;
    if (bus.alu_valid && (bus.alu_addr != REG_ZERO)) src = WB_ALU;
    else if (pop)                                    src = WB_FIFO;
  end

  // Clear on pop first so a same-cycle issue to that register re-sets it.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head.addr] = 1'b0;
    if (bus.issue_valid && (bus.issue_addr != REG_ZERO))
      busy_next[bus.issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    wait_next = wait_cnt;
    if (pop || fifo_empty)                 wait_next = '0;
    else if (wait_cnt < WW'(STARVE_LIMIT)) wait_next = wait_cnt + 1'b1;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
      busy     <= '0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_next;
      stall_q  <= (wait_next >= WW'(STARVE_LIMIT));
      busy     <= busy_next;
      if (bus.alu_valid && stall_q) err_q <= 1'b1;
      case (src)
        WB_ALU: begin
          wen_q   <= 1'b1;
          waddr_q <= bus.alu_addr;
          wdata_q <= bus.alu_data;
        end
        WB_FIFO: begin
          wen_q   <= 1'b1;
          waddr_q <= head.addr;
          wdata_q <= head.data;
        end
        default: wen_q <= 1'b0;
      endcase
    end
  end

  assign bus.wEn       = wen_q;
  assign bus.wAddr     = waddr_q;
  assign bus.wData     = wdata_q;
  assign bus.alu_stall = stall_q;
  assign bus.err       = err_q;
  assign bus.r0_busy   = busy[bus.r0Addr];
  assign bus.r1_busy   = busy[bus.r1Addr];
endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// Bench for regbank_wb_ctrl: vector table for single-cycle behaviour, a
// write-order scoreboard fed by a small reference model, and corner sequences.
module tb_regbank_wb_ctrl;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  regbank_wb_ctrl_if #(.DW(32), .AW(5)) bus ();

  regbank_wb_ctrl #(
    .DW(32), .AW(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(3)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        mdu_v;
    logic [4:0]  mdu_a;
    logic [31:0] mdu_d;
    logic        e_ready;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  mq[$];
  wr_t  exp_q[$];
  wr_t  e;
  logic m_rdy;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mdu_valid = mv; bus.mdu_addr = ma; bus.mdu_data = md;
  endtask

  // Reference model: predicts each edge's write and queues it for comparison.
  always begin
    @(posedge CLK);
    if (reset) begin
      mq.delete();
      exp_q.delete();
    end else begin
      m_rdy = (mq.size() != DEPTH);
      if (bus.alu_valid && bus.alu_addr != 5'd0)
        exp_q.push_back(wr_t'{addr: bus.alu_addr, data: bus.alu_data});
      else if (mq.size() > 0)
        exp_q.push_back(mq.pop_front());
      if (bus.mdu_valid && m_rdy && bus.mdu_addr != 5'd0)
        mq.push_back(wr_t'{addr: bus.mdu_addr, data: bus.mdu_data});
      #1;
      if (!reset) begin
        chk("sb_mdu_ready", bus.mdu_ready, mq.size() != DEPTH);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_wen", bus.wEn, 1);
          if (bus.wEn) begin
            chk("sb_waddr", bus.wAddr, e.addr);
            chk("sb_wdata", bus.wData, e.data);
          end
        end else begin
          chk("sb_idle_wen", bus.wEn, 0);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h22222222, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd31, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 5'd2,  32'h00000003, 1'b1, 5'd6, 32'h00000066, 1'b1, 1'b1, 5'd2,  32'h00000003};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd6,  32'h00000066};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd6,  32'h00000066};

    drive(0, 0, 0, 0, 0, 0);
    bus.issue_valid = 0; bus.issue_addr = 0; bus.r0Addr = 0; bus.r1Addr = 0;
    #1;
    chk("rst_wen", bus.wEn, 0);
    chk("rst_waddr", bus.wAddr, 0);
    chk("rst_wdata", bus.wData, 0);
    chk("rst_stall", bus.alu_stall, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ready", bus.mdu_ready, 0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;

    // Single-cycle write select, r0 writes, MDU handshake to r0
    foreach (vecs[i]) begin
      drive(vecs[i].alu_v, vecs[i].alu_a, vecs[i].alu_d,
            vecs[i].mdu_v, vecs[i].mdu_a, vecs[i].mdu_d);
      #1;
      chk($sformatf("vec%0d_ready", i), bus.mdu_ready, vecs[i].e_ready);
      tick();
      chk($sformatf("vec%0d_wen", i), bus.wEn, vecs[i].e_wen);
      chk($sformatf("vec%0d_waddr", i), bus.wAddr, vecs[i].e_addr);
      chk($sformatf("vec%0d_wdata", i), bus.wData, vecs[i].e_data);
    end
    drive(0, 0, 0, 0, 0, 0);

    // Scoreboard lifetime of an MDU destination
    bus.issue_valid = 1; bus.issue_addr = 9; bus.r0Addr = 9; bus.r1Addr = 3;
    #1;
    chk("busy9_pre_issue", bus.r0_busy, 0);
    tick();
    bus.issue_valid = 0;
    chk("busy9_after_issue", bus.r0_busy, 1);
    chk("busy3_clear", bus.r1_busy, 0);
    drive(0, 0, 0, 1, 9, 32'h1234);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("mdu9_lat1_wen", bus.wEn, 0);
    chk("busy9_before_pop", bus.r0_busy, 1);
    tick();
    chk("mdu9_wen", bus.wEn, 1);
    chk("mdu9_waddr", bus.wAddr, 9);
    chk("mdu9_wdata", bus.wData, 32'h1234);
    chk("busy9_after_pop", bus.r0_busy, 0);

    // Fill the FIFO while the ALU holds the port, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(20 + i), 32'(i), 1, 5'(i), 32'(32'h100 + i));
      #1;
      chk("fill_ready", bus.mdu_ready, 1);
      tick();
      chk($sformatf("fill%0d_stall", i), bus.alu_stall, i == 4);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("full_ready", bus.mdu_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("drain%0d_wen", i), bus.wEn, 1);
      chk($sformatf("drain%0d_waddr", i), bus.wAddr, i);
      chk($sformatf("drain%0d_wdata", i), bus.wData, 32'h100 + i);
      chk($sformatf("drain%0d_stall", i), bus.alu_stall, 0);
    end
    tick();
    chk("drained_wen", bus.wEn, 0);
    chk("drain_err", bus.err, 0);

    // Issue and pop of the same register in one cycle: set wins
    drive(0, 0, 0, 1, 7, 32'h77);
    bus.r0Addr = 7;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    bus.issue_valid = 1; bus.issue_addr = 7;
    #1;
    chk("busy7_pre", bus.r0_busy, 0);
    tick();
    bus.issue_valid = 0;
    chk("same_cycle_waddr", bus.wAddr, 7);
    chk("busy7_set_wins", bus.r0_busy, 1);
    tick();
    chk("busy7_holds", bus.r0_busy, 1);

    // ALU write while stalled sets the sticky error
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(13 + k), 32'(32'hA0 + k), k == 0, 8, 32'h88);
      tick();
      chk($sformatf("starve%0d_stall", k), bus.alu_stall, k == 3);
    end
    chk("err_before_violation", bus.err, 0);
    drive(1, 17, 32'hBAD, 0, 0, 0);
    tick();
    chk("violation_waddr", bus.wAddr, 17);
    chk("violation_err", bus.err, 1);
    chk("violation_stall", bus.alu_stall, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("starved_pop_waddr", bus.wAddr, 8);
    chk("err_sticky1", bus.err, 1);
    tick();
    chk("err_sticky2", bus.err, 1);
    chk("stall_released", bus.alu_stall, 0);

    // Reset with three entries queued and pending busy bits
    bus.issue_valid = 1; bus.issue_addr = 11;
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(24 + k), 32'(k), 1, 5'(21 + k), 32'(32'h200 + k));
      tick();
      bus.issue_valid = 0;
    end
    bus.r0Addr = 11; bus.r1Addr = 7;
    #1;
    chk("busy11_pre_reset", bus.r0_busy, 1);
    drive(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_wen", bus.wEn, 0);
    chk("mid_rst_ready", bus.mdu_ready, 0);
    chk("mid_rst_err", bus.err, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", bus.mdu_ready, 1);
    chk("post_rst_busy0", bus.r0_busy, 0);
    chk("post_rst_busy1", bus.r1_busy, 0);
    chk("post_rst_stall", bus.alu_stall, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_stale_wen", bus.wEn, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regbank_wb_ctrl.md
Name: regbank_wb_ctrl

Overview:
Writeback controller and pending-write scoreboard that drives the register bank write port (wAddr/wData/wEn).
- Merges results from two producers:
  - the single-cycle ALU path, which always has priority and has no backpressure;
  - the multi-cycle mul/div unit (MDU), which uses a valid/ready handshake and is buffered in a small FIFO.
- Tracks which registers have an outstanding MDU write, so decode can stall on read-after-write hazards.

Parameters:
DW, 32, data width of a register
AW, 5, register address width (32 registers)
FIFO_DEPTH, 4, MDU result buffer entries; must be a power of two and at least 2
STARVE_LIMIT, 3, cycles the FIFO head may wait before alu_stall is raised

Ports:
CLK  in  1  clock
reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result present this cycle
alu_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
mdu_valid  in  1  MDU result offered
mdu_ready  out  1  MDU result accepted when mdu_valid and mdu_ready are both high
mdu_addr  in  AW  MDU destination register
mdu_data  in  DW  MDU result
issue_valid  in  1  MDU operation issued this cycle
issue_addr  in  AW  destination register of the issued MDU operation
r0Addr  in  AW  decode read address 0 (scoreboard query)
r1Addr  in  AW  decode read address 1 (scoreboard query)
r0_busy  out  1  register r0Addr has a pending MDU write
r1_busy  out  1  register r1Addr has a pending MDU write
alu_stall  out  1  request to upstream: hold alu_valid low next cycle
wAddr  out  AW  register bank write address
wData  out  DW  register bank write data
wEn  out  1  register bank write enable
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (asynchronous, active-high):
  - wEn=0, wAddr=0, wData=0, alu_stall=0, err=0.
  - FIFO emptied (pointers and count = 0); scoreboard busy[31:0]=0; wait counter=0.
  - Asserting reset mid-operation discards all FIFO contents and pending state.
- mdu_ready = (count != FIFO_DEPTH) and not reset; it is combinational from the count.
- MDU ingress: on a handshake with mdu_addr != 0, push {addr, data} into the FIFO. A handshake with mdu_addr == 0 is accepted and dropped.
- Per-cycle write select, outputs registered at the clock edge:
  1. alu_valid=1 and alu_addr!=0: wEn<=1, wAddr<=alu_addr, wData<=alu_data.
  2. Otherwise, FIFO non-empty: pop the head; wEn<=1, wAddr/wData <= head.
  3. Otherwise: wEn<=0; wAddr and wData hold their values.
  - alu_valid with alu_addr==0 writes nothing but still blocks the FIFO pop that cycle.
- Latency:
  - ALU result to wEn: 1 cycle.
  - MDU handshake to wEn: at least 2 cycles (push, then pop).
- Push and pop in the same cycle: count is unchanged. A push into a full FIFO is impossible because mdu_ready=0.
- FIFO pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits wide.
- Scoreboard:
  - Set: issue_valid and issue_addr!=0 sets busy[issue_addr].
  - Clear: a FIFO pop clears busy[head.addr].
  - Set and clear of the same address in the same cycle: set wins.
  - ALU writes never touch the scoreboard.
  - busy[0] is always 0.
  - r0_busy = busy[r0Addr] and r1_busy = busy[r1Addr], combinational, using the pre-edge state.
- Starvation control:
  - The wait counter increments each cycle the FIFO is non-empty and no pop occurs. It resets to 0 on any pop or when the FIFO is empty. It saturates at STARVE_LIMIT.
  - alu_stall<=1 when the next wait count is >= STARVE_LIMIT; it deasserts the cycle after a pop.
  - While alu_stall=1, upstream must keep alu_valid=0. If alu_valid=1 anyway, the ALU still wins and err is set and stays set until reset.

Decomposition:
- Shared package regbank_pkg:
  - constants REG_AW=5, REG_DW=32, REG_ZERO=0;
  - typedef wb_entry_t {addr, data}.
- One sub-module: wb_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count outputs and asynchronous reset.
- Select logic, scoreboard and starvation counter stay in the top level.

Test Plan:
1. Reset release; alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF -> next cycle wEn=1, wAddr=5, wData=0xDEADBEEF; the following idle cycle wEn=0.
2. issue_valid=1, issue_addr=9; later MDU handshake addr=9, data=0x1234; r0Addr=9 -> r0_busy=1 until the pop cycle; wEn=1, wAddr=9, wData=0x1234 2 cycles after the handshake; r0_busy=0 after that edge.
3. Four back-to-back MDU pushes (addr 1-4) while alu_valid=1 continuously -> mdu_ready=0 after the 4th push; alu_stall=1 after 3 waiting cycles; when alu_valid drops, entries 1, 2, 3, 4 are written in order on consecutive cycles.
4. alu_addr=0 and mdu_addr=0 writes -> wEn never asserted; the MDU handshake completes (mdu_ready=1); FIFO count stays 0.
5. Same-cycle issue_addr=7 and FIFO pop of addr 7 -> busy[7] remains 1. Also alu_valid=1 while alu_stall=1 -> the ALU write occurs and err=1 stays sticky.
6. Assert reset with 3 FIFO entries and busy bits set -> wEn=0, mdu_ready=1 after release, r0_busy=r1_busy=0, and no stale writes appear.
